mpu_cmd_sequencer: RTL and testbench

Command sequencer for the MPU datapath. It accepts one decoded host command at a time (NONE, LOAD or MULTIPLY) from the frame parser and validates its fields. It then drives the operand-buffer write port, or the MMU row feed and result collection, and finally emits one response frame type to the frame builder. It also latches the activation and pooling selection for the post-processing stage, and tracks which operand buffers hold valid data.

---
 rtl/mpu_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mpu_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mpu_cmd_sequencer.sv
// mpu_cmd_sequencer: validates one host command at a time and sequences operand-buffer loads, MMU row feed and result collection, then emits a response type.
// Ports: cmd_* (command handshake and fields), row_valid/row_ready (LOAD rows), buf_we/buf_sel/buf_addr (buffer port),
//        mmu_feed/mmu_res_valid (MMU), act_sel/pool_sel (post-processing selects), rsp_* (response handshake), busy.
module mpu_cmd_sequencer #(
    parameter int MATRIX_SIZE = 10,
    parameter int BUFFER_CNT  = 4,
    parameter int RES_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd,
    input  logic [7:0]                    cmd_buf,
    input  logic [7:0]                    cmd_rows,
    input  logic [7:0]                    cmd_act,
    input  logic [7:0]                    cmd_pool,
    input  logic                          row_valid,
    output logic                          row_ready,
    output logic                          buf_we,
    output logic [$clog2(BUFFER_CNT)-1:0] buf_sel,
    output logic [$clog2(MATRIX_SIZE)-1:0] buf_addr,
    output logic                          mmu_feed,
    input  logic                          mmu_res_valid,
    output logic [7:0]                    act_sel,
    output logic [7:0]                    pool_sel,
    output logic                          rsp_valid,
    output logic [2:0]                    rsp_type,
    input  logic                          rsp_ready,
    output logic                          busy
);
    localparam int AW = $clog2(MATRIX_SIZE);
    localparam int BW = $clog2(BUFFER_CNT);
    localparam int IW = $clog2(RES_TIMEOUT) + 1;
    localparam logic [7:0] CMD_NONE = 8'd0, CMD_LOAD = 8'd1, CMD_MULTIPLY = 8'd2;
    localparam logic [7:0] ACTIVATION_NONE = 8'd0, ACTIVATION_RELU = 8'd1;
    localparam logic [7:0] POOLING_NONE = 8'd0, POOLING_MAX = 8'd1;
    localparam logic [2:0] FRAME_NONE = 3'd0, FRAME_DATA = 3'd1, FRAME_ERR_CMD = 3'd2,
                           FRAME_ERR_DIM = 3'd3, FRAME_ERR_FRAME = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            rows_q, rows_d, cnt_q, cnt_d, res_q, res_d, res_n;
    logic [IW-1:0]         idle_q, idle_d;
    logic [BUFFER_CNT-1:0] valid_q, valid_d;
    logic [7:0]            buf_rows_q [BUFFER_CNT];
    logic [7:0]            buf_rows_d [BUFFER_CNT];
    logic                  cmd_ready_q, cmd_ready_d, row_ready_q, row_ready_d, buf_we_q, buf_we_d;
    logic                  mmu_feed_q, mmu_feed_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic [BW-1:0]         buf_sel_q, buf_sel_d;
    logic [AW-1:0]         buf_addr_q, buf_addr_d;
    logic [7:0]            act_sel_q, act_sel_d, pool_sel_q, pool_sel_d;
    logic [2:0]            rsp_type_q, rsp_type_d;
    logic                  fields_ok, dim_ok, mul_ok;

    assign fields_ok = (cmd == CMD_NONE || cmd == CMD_LOAD || cmd == CMD_MULTIPLY)
                    && (cmd_act == ACTIVATION_NONE || cmd_act == ACTIVATION_RELU)
                    && (cmd_pool == POOLING_NONE || cmd_pool == POOLING_MAX);
    assign dim_ok    = cmd_rows != 8'd0 && int'(cmd_rows) <= MATRIX_SIZE;
    assign mul_ok    = valid_q[0] && valid_q[1] && buf_rows_q[0] == cmd_rows && buf_rows_q[1] == cmd_rows;
    assign res_n     = res_q + {7'd0, mmu_res_valid};

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        idle_d      = idle_q;
        valid_d     = valid_q;
        buf_rows_d  = buf_rows_q;
        row_ready_d = 1'b0;
        buf_we_d    = 1'b0;
        mmu_feed_d  = 1'b0;
        buf_sel_d   = buf_sel_q;
        buf_addr_d  = buf_addr_q;
        act_sel_d   = act_sel_q;
        pool_sel_d  = pool_sel_q;
        rsp_type_d  = rsp_type_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                rows_d  = cmd_rows;
                cnt_d   = 8'd0;
                res_d   = 8'd0;
                idle_d  = '0;
                state_d = S_RESP;
                if (!fields_ok || (cmd == CMD_LOAD && int'(cmd_buf) >= BUFFER_CNT)) rsp_type_d = FRAME_ERR_CMD;
                else if (cmd != CMD_NONE && !dim_ok) rsp_type_d = FRAME_ERR_DIM;
                else if (cmd == CMD_MULTIPLY && !mul_ok) rsp_type_d = FRAME_ERR_DIM;
                else if (cmd == CMD_LOAD) begin
                    // Invalidate up front so an interrupted load can never be multiplied.
                    state_d                  = S_LOAD;
                    row_ready_d              = 1'b1;
                    buf_sel_d                = cmd_buf[BW-1:0];
                    valid_d[cmd_buf[BW-1:0]] = 1'b0;
                end else if (cmd == CMD_MULTIPLY) begin
                    state_d    = S_FEED;
                    mmu_feed_d = 1'b1;
                    buf_sel_d  = '0;
                    buf_addr_d = '0;
                    cnt_d      = 8'd1;
                    act_sel_d  = cmd_act;
                    pool_sel_d = cmd_pool;
                end else rsp_type_d = FRAME_NONE;
            end
            S_LOAD: begin
                // row_ready already low means the last write is on the port now.
                if (!row_ready_q) begin
                    state_d               = S_RESP;
                    rsp_type_d            = FRAME_NONE;
                    valid_d[buf_sel_q]    = 1'b1;
                    buf_rows_d[buf_sel_q] = rows_q;
                end else if (row_valid) begin
                    buf_we_d    = 1'b1;
                    buf_addr_d  = cnt_q[AW-1:0];
                    cnt_d       = cnt_q + 8'd1;
                    row_ready_d = cnt_q + 8'd1 != rows_q;
                end else row_ready_d = 1'b1;
            end
            S_FEED, S_DRAIN: begin
                res_d  = res_n;
                idle_d = mmu_res_valid ? '0 : idle_q + IW'(1);
                if (state_q == S_FEED) begin
                    if (cnt_q == rows_q) state_d = S_DRAIN;
                    else begin
                        mmu_feed_d = 1'b1;
                        buf_addr_d = cnt_q[AW-1:0];
                        cnt_d      = cnt_q + 8'd1;
                    end
                end else if (res_n >= rows_q) begin
                    state_d    = S_RESP;
                    rsp_type_d = FRAME_DATA;
                end else if (idle_d >= IW'(RES_TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    rsp_type_d = FRAME_ERR_FRAME;
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = state_d == S_IDLE;
        busy_d      = state_d != S_IDLE;
        rsp_valid_d = state_d == S_RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            idle_q      <= '0;
            valid_q     <= '0;
            buf_rows_q  <= '{default: '0};
            cmd_ready_q <= 1'b1;
            row_ready_q <= 1'b0;
            buf_we_q    <= 1'b0;
            mmu_feed_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            buf_sel_q   <= '0;
            buf_addr_q  <= '0;
            act_sel_q   <= ACTIVATION_NONE;
            pool_sel_q  <= POOLING_NONE;
            rsp_type_q  <= FRAME_NONE;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            idle_q      <= idle_d;
            valid_q     <= valid_d;
            buf_rows_q  <= buf_rows_d;
            cmd_ready_q <= cmd_ready_d;
            row_ready_q <= row_ready_d;
            buf_we_q    <= buf_we_d;
            mmu_feed_q  <= mmu_feed_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            buf_sel_q   <= buf_sel_d;
            buf_addr_q  <= buf_addr_d;
            act_sel_q   <= act_sel_d;
            pool_sel_q  <= pool_sel_d;
            rsp_type_q  <= rsp_type_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign row_ready = row_ready_q;
    assign buf_we    = buf_we_q;
    assign buf_sel   = buf_sel_q;
    assign buf_addr  = buf_addr_q;
    assign mmu_feed  = mmu_feed_q;
    assign act_sel   = act_sel_q;
    assign pool_sel  = pool_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_type  = rsp_type_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// tb_mpu_cmd_sequencer: directed and randomized command streams checked cycle by cycle against a transaction-level model.
module tb_mpu_cmd_sequencer;
    localparam int MS = 10, BC = 4, RT = 64;
    localparam logic [7:0] C_NONE = 8'd0, C_LOAD = 8'd1, C_MUL = 8'd2;
    localparam int F_NONE = 0, F_DATA = 1, F_ERR_CMD = 2, F_ERR_DIM = 3, F_ERR_FRAME = 4;

    logic       clk = 1'b0, rst_n;
    logic       cmd_valid, cmd_ready, row_valid, row_ready, buf_we, mmu_feed, mmu_res_valid;
    logic       rsp_valid, rsp_ready, busy;
    logic [7:0] cmd, cmd_buf, cmd_rows, cmd_act, cmd_pool, act_sel, pool_sel;
    logic [1:0] buf_sel;
    logic [3:0] buf_addr;
    logic [2:0] rsp_type;

    mpu_cmd_sequencer #(.MATRIX_SIZE(MS), .BUFFER_CNT(BC), .RES_TIMEOUT(RT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_buf(cmd_buf), .cmd_rows(cmd_rows), .cmd_act(cmd_act), .cmd_pool(cmd_pool),
        .row_valid(row_valid), .row_ready(row_ready), .buf_we(buf_we), .buf_sel(buf_sel),
        .buf_addr(buf_addr), .mmu_feed(mmu_feed), .mmu_res_valid(mmu_res_valid),
        .act_sel(act_sel), .pool_sel(pool_sel), .rsp_valid(rsp_valid), .rsp_type(rsp_type),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;
    logic e_cr, e_busy, e_rr, e_we, e_feed, e_rv, e_hold;
    logic [2:0] e_type;
    logic [7:0] e_act, e_pool;
    int e_sel, e_addr;
    bit mvalid [BC];
    logic [7:0] mrows [BC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cmd_ready", cmd_ready, e_cr);
        chk("busy", busy, e_busy);
        chk("row_ready", row_ready, e_rr);
        chk("buf_we", buf_we, e_we);
        chk("mmu_feed", mmu_feed, e_feed);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("act_sel", act_sel, e_act);
        chk("pool_sel", pool_sel, e_pool);
        if (e_we || e_feed || e_hold) begin
            chk("buf_sel", buf_sel, e_sel);
            chk("buf_addr", buf_addr, e_addr);
        end
        if (e_rv) chk("rsp_type", rsp_type, e_type);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        {e_cr, e_busy, e_rr, e_we, e_feed, e_rv, e_hold} = 7'b1000000;
    endtask

    task automatic set_busy();
        {e_cr, e_busy, e_rr, e_we, e_feed, e_rv, e_hold} = 7'b0100000;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_row_ready"}, row_ready, 0);
        chk({tag, "_buf_we"}, buf_we, 0);
        chk({tag, "_mmu_feed"}, mmu_feed, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_type"}, rsp_type, F_NONE);
        chk({tag, "_act_sel"}, act_sel, 0);
        chk({tag, "_pool_sel"}, pool_sel, 0);
        chk({tag, "_buf_sel"}, buf_sel, 0);
        chk({tag, "_buf_addr"}, buf_addr, 0);
    endtask

    // kind: 0 = straight to response, 1 = load, 2 = multiply
    task automatic predict(input logic [7:0] c, b, r, a, p, input int np, output int kind, output int rsp);
        kind = 0;
        if (c > C_MUL || a > 8'd1 || p > 8'd1) rsp = F_ERR_CMD;
        else if (c == C_LOAD && int'(b) >= BC) rsp = F_ERR_CMD;
        else if (c != C_NONE && (r == 8'd0 || int'(r) > MS)) rsp = F_ERR_DIM;
        else if (c == C_MUL && !(mvalid[0] && mvalid[1] && mrows[0] == r && mrows[1] == r)) rsp = F_ERR_DIM;
        else if (c == C_NONE) rsp = F_NONE;
        else if (c == C_LOAD) begin kind = 1; rsp = F_NONE; end
        else begin kind = 2; rsp = (np >= int'(r)) ? F_DATA : F_ERR_FRAME; end
    endtask

    task automatic run_cmd(input logic [7:0] c, b, r, a, p, input int np, rdly, gap, abort_row, lit);
        int kind, rsp, k, got, fp;
        logic rv, was_rr, ph;
        predict(c, b, r, a, p, np, kind, rsp);
        if (lit >= 0) chk("model_pin", rsp, lit);
        cmd_valid = 1; cmd = c; cmd_buf = b; cmd_rows = r; cmd_act = a; cmd_pool = p;
        mmu_res_valid = 1; row_valid = 1;
        tick();
        cmd_valid = 0; mmu_res_valid = 0; row_valid = 0;
        set_busy();
        if (kind == 1) begin
            mvalid[b] = 0;
            e_rr = 1; k = 0; ph = 0;
            while (1) begin
                if (abort_row >= 0 && k == abort_row) begin
                    chk_en = 0;
                    #2 rst_n = 0;
                    #1 chk_reset("async_rst");
                    row_valid = 0; rst_n = 1;
                    for (int i = 0; i < BC; i++) begin mvalid[i] = 0; mrows[i] = 0; end
                    e_act = 0; e_pool = 0;
                    tick();
                    set_idle(); chk_en = 1;
                    return;
                end
                rv = (k < int'(r) && gap != 0) ? ph : 1'($urandom % 2);
                ph = ~ph; row_valid = rv; was_rr = e_rr;
                tick();
                if (!was_rr) break;
                e_we = rv;
                if (rv) begin e_sel = int'(b); e_addr = k; k++; end
                e_hold = !rv && k > 0;
                e_rr = k < int'(r);
            end
            row_valid = 0;
            mvalid[b] = 1; mrows[b] = r;
        end else if (kind == 2) begin
            e_act = a; e_pool = p; got = 0;
            fp = np > 1 ? int'($urandom_range(0, np - 1)) : 0;
            for (int i = 0; i < int'(r); i++) begin
                e_feed = 1; e_sel = 0; e_addr = i;
                mmu_res_valid = fp > 0 && ($urandom % 2 == 1);
                if (mmu_res_valid) begin fp--; got++; end
                tick();
            end
            e_feed = 0;
            while (got < np) begin
                for (int g = int'($urandom_range(0, 4)); g > 0; g--) begin mmu_res_valid = 0; tick(); end
                mmu_res_valid = 1; got++;
                tick();
            end
            mmu_res_valid = 0;
            if (np < int'(r)) repeat (RT - 1) tick();
        end
        set_busy(); e_rv = 1; e_type = 3'(rsp);
        if (lit >= 0) chk("rsp_lit", rsp_type, lit);
        for (int d = 0; d < rdly; d++) begin
            rsp_ready = 0; cmd_valid = 1; cmd = C_NONE; mmu_res_valid = 1'($urandom % 2);
            tick();
        end
        rsp_ready = 1; cmd_valid = 1; cmd = C_NONE;
        tick();
        rsp_ready = 0; cmd_valid = 0; mmu_res_valid = 0;
        set_idle();
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd = 0; cmd_buf = 0; cmd_rows = 0; cmd_act = 0; cmd_pool = 0;
        row_valid = 0; mmu_res_valid = 0; rsp_ready = 0;
        e_act = 0; e_pool = 0; e_sel = 0; e_addr = 0; e_type = 0;
        for (int i = 0; i < BC; i++) begin mvalid[i] = 0; mrows[i] = 0; end
        set_idle();
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        rst_n = 1;
        tick();
        chk_en = 1;
        run_cmd(C_NONE, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0, -1, F_NONE);
        run_cmd(C_LOAD, 8'd0, 8'd10, 8'd0, 8'd0, 0, 1, 1, -1, F_NONE);
        run_cmd(C_LOAD, 8'd1, 8'd10, 8'd0, 8'd0, 0, 0, 1, -1, F_NONE);
        run_cmd(C_MUL, 8'd0, 8'd10, 8'd1, 8'd1, 10, 0, 0, -1, F_DATA);
        chk("act_relu", act_sel, 1);
        chk("pool_max", pool_sel, 1);
        run_cmd(8'h07, 8'd0, 8'd5, 8'd0, 8'd0, 0, 0, 0, -1, F_ERR_CMD);
        run_cmd(C_LOAD, 8'd4, 8'd5, 8'd0, 8'd0, 0, 0, 0, -1, F_ERR_CMD);
        run_cmd(C_LOAD, 8'd0, 8'd11, 8'd0, 8'd0, 0, 0, 0, -1, F_ERR_DIM);
        run_cmd(C_MUL, 8'd0, 8'd5, 8'd0, 8'd0, 5, 0, 0, -1, F_ERR_DIM);
        run_cmd(C_MUL, 8'd0, 8'd10, 8'd0, 8'd0, 9, 1, 0, -1, F_ERR_FRAME);
        run_cmd(C_LOAD, 8'd1, 8'd10, 8'd0, 8'd0, 0, 0, 1, 5, -1);
        run_cmd(C_MUL, 8'd0, 8'd10, 8'd0, 8'd0, 10, 3, 0, -1, F_ERR_DIM);
        run_cmd(C_LOAD, 8'd0, 8'd10, 8'd0, 8'd0, 0, 0, 0, -1, F_NONE);
        run_cmd(C_MUL, 8'd0, 8'd10, 8'd0, 8'd0, 10, 0, 0, -1, F_ERR_DIM);
        for (int n = 0; n < 60; n++) begin
            logic [7:0] c, b, r, a, p;
            int u, np;
            u = int'($urandom % 10);
            c = u == 0 ? C_NONE : u < 5 ? C_LOAD : u < 9 ? C_MUL : 8'($urandom_range(3, 255));
            b = ($urandom % 8 < 6) ? 8'($urandom % 2) : 8'($urandom_range(2, 7));
            u = int'($urandom % 7);
            r = u < 2 ? 8'd10 : u < 4 ? 8'd3 : u == 4 ? 8'd0 : u == 5 ? 8'd11 : 8'($urandom_range(1, 12));
            a = ($urandom % 10 == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom % 2);
            p = ($urandom % 10 == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom % 2);
            np = (r > 8'd1 && $urandom % 4 == 0) ? int'($urandom_range(1, int'(r) - 1)) : int'(r);
            run_cmd(c, b, r, a, p, np, int'($urandom % 3), int'($urandom % 2), -1, -1);
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
